tt_pin_delay_router: RTL and testbench

Parametrised successor to the plain pin pass-through in the TinyTapeout user wrapper. It routes a WIDTH-bit input bus to the output bus through a programmable-depth delay line. It applies one of four runtime modes (pass, invert, edge-detect, off) and drives a programmable output-enable mask. Configuration is loaded through a valid/ready handshake. A fill counter flags when the output again reflects only post-configuration data. It sits between the wrapper's `ui_in`/`uio_in` pins and `uo_out`/`uio_out`/`uio_oe`.

---
 rtl/tt_pin_router_pkg.sv | 24 ++
 rtl/tt_delay_line.sv | 41 ++++
 rtl/tt_pin_delay_router.sv | 109 ++++++++++
 tb/tb_tt_pin_delay_router.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_router_pkg.sv
// Shared types and helpers for the TinyTapeout pin delay router.
//   mode_t      : runtime routing mode (PASS / INV / EDGE / OFF)
//   clamp_delay : maps a requested delay onto the legal range 1..depth
package tt_pin_router_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_EDGE = 2'd2,
    MODE_OFF  = 2'd3
  } mode_t;

  // A request of 0 would have no tap to read, so it becomes 1.
  // Anything past the end of the line selects the last stage.
  function automatic int clamp_delay(input int req, input int depth);
    if (req < 1) begin
      return 1;
    end else if (req > depth) begin
      return depth;
    end
    return req;
  endfunction

endpackage

// File: rtl/tt_delay_line.sv
// WIDTH x DEPTH shift register with advance enable.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   ena      : shift enable; the line holds when low
//   din      : data entering stage 0
//   stages   : all stage contents, stages[0] is the newest sample
module tt_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [WIDTH-1:0]             din,
  output logic [DEPTH-1:0][WIDTH-1:0]  stages
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            stages[0] <= '0;
          end else if (ena) begin
            stages[0] <= din;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            stages[gi] <= '0;
          end else if (ena) begin
            stages[gi] <= stages[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tt_pin_delay_router.sv
// Routes a WIDTH-bit input bus to the output through a programmable-depth
// delay line, applying a runtime mode and an output-enable mask.
// Ports:
//   clk, rst          : clock and asynchronous active-high reset
//   ena               : advance enable for the delay line and fill counter
//   din               : input data
//   cfg_valid/ready   : configuration handshake
//   cfg_mode/delay/oe : configuration payload
//   dout, dout_valid  : routed data, and flag that it is post-config only
//   oe, mode          : active output-enable mask and mode
module tt_pin_delay_router
  import tt_pin_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DW-1:0]    cfg_delay,
  input  logic [WIDTH-1:0] cfg_oe,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] oe,
  output logic [1:0]       mode
);

  logic [DEPTH-1:0][WIDTH-1:0] stages;
  mode_t                       mode_reg;
  logic [DW-1:0]               d_reg;
  logic [DW-1:0]               fc_reg;
  logic [WIDTH-1:0]            oe_reg;
  logic                        cfg_ready_reg;
  logic                        accept;
  logic [DW-1:0]               d_next;
  logic [WIDTH-1:0]            tap;
  logic [WIDTH-1:0]            dout_raw;

  tt_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_line (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .din    (din),
    .stages (stages)
  );

  assign accept = cfg_valid && cfg_ready_reg;
  assign d_next = DW'(clamp_delay(int'(cfg_delay), DEPTH));

  // Config registers, handshake and fill counter. An accept clears the
  // fill counter even if ena shifts the line in the same cycle, so valid
  // output always waits for d fresh samples under the new setting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg      <= MODE_PASS;
      d_reg         <= DW'(1);
      oe_reg        <= '0;
      fc_reg        <= '0;
      cfg_ready_reg <= 1'b1;
    end else begin
      // Accept only happens with ready high, so this yields a single
      // low cycle after each accept.
      cfg_ready_reg <= !accept;
      if (accept) begin
        mode_reg <= mode_t'(cfg_mode);
        d_reg    <= d_next;
        oe_reg   <= cfg_oe;
        fc_reg   <= '0;
      end else if (ena && (fc_reg != d_reg)) begin
        fc_reg <= fc_reg + DW'(1);
      end
    end
  end

  // Tap select: stage d-1, d is always in 1..DEPTH.
  always_comb begin
    tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (d_reg == DW'(i + 1)) begin
        tap = stages[i];
      end
    end
  end

  always_comb begin
    dout_raw = '0;
    case (mode_reg)
      MODE_PASS: dout_raw = tap;
      MODE_INV:  dout_raw = ~tap;
      MODE_EDGE: dout_raw = stages[0] ^ tap;  // zero naturally when d = 1
      default:   dout_raw = '0;
    endcase
  end

  assign dout_valid = (fc_reg == d_reg) && (mode_reg != MODE_OFF);
  assign dout       = dout_valid ? dout_raw : '0;
  assign oe         = (mode_reg == MODE_OFF) ? '0 : oe_reg;
  assign mode       = mode_reg;
  assign cfg_ready  = cfg_ready_reg;

endmodule

// File: tb/tb_tt_pin_delay_router.sv
module tb_tt_pin_delay_router;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [WIDTH-1:0] din;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DW-1:0]    cfg_delay;
  logic [WIDTH-1:0] cfg_oe;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [WIDTH-1:0] oe;
  logic [1:0]       mode;

  int n_vec = 0;
  int n_err = 0;

  tt_pin_delay_router #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .din        (din),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_delay  (cfg_delay),
    .cfg_oe     (cfg_oe),
    .dout       (dout),
    .dout_valid (dout_valid),
    .oe         (oe),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a configuration, wait (bounded) for acceptance, and check the
  // one-cycle ready drop that follows.
  task automatic configure(input logic [1:0] m, input logic [DW-1:0] dl, input logic [WIDTH-1:0] o);
    int guard;
    guard     = 0;
    cfg_mode  = m;
    cfg_delay = dl;
    cfg_oe    = o;
    cfg_valid = 1'b1;
    while (!cfg_ready && guard < 10) begin
      step();
      guard++;
    end
    if (guard >= 10) check_vec("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    check_vec("rdy_drop", 32'(cfg_ready), 32'd0);
    check_vec("mode_upd", 32'(mode), 32'(m));
    step();
    check_vec("rdy_back", 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; din = '0;
    cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_delay = '0; cfg_oe = '0;
    #3;
    check_vec("rst_dout",  32'(dout), 32'h0);
    check_vec("rst_valid", 32'(dout_valid), 32'h0);
    check_vec("rst_oe",    32'(oe), 32'h0);
    check_vec("rst_mode",  32'(mode), 32'h0);
    check_vec("rst_ready", 32'(cfg_ready), 32'h1);
    step(); step();
    rst = 1'b0;

    // Default PASS, d=1
    ena = 1'b1; din = 8'hA5;
    step();
    check_vec("d1_valid", 32'(dout_valid), 32'h1);
    check_vec("d1_dout",  32'(dout), 32'hA5);
    ena = 1'b0;

    // PASS d=3, oe F0
    configure(2'd0, 3'd3, 8'hF0);
    check_vec("d3_oe", 32'(oe), 32'hF0);
    check_vec("d3_valid0", 32'(dout_valid), 32'h0);
    ena = 1'b1;
    din = 8'h01; step();
    din = 8'h02; step();
    check_vec("d3_valid2", 32'(dout_valid), 32'h0);
    check_vec("d3_dout_inv", 32'(dout), 32'h0);
    din = 8'h03; step();
    check_vec("d3_valid3", 32'(dout_valid), 32'h1);
    check_vec("d3_dout", 32'(dout), 32'h01);
    din = 8'h04; step();
    check_vec("d3_dout_next", 32'(dout), 32'h02);
    ena = 1'b0;

    // INV d=2
    configure(2'd1, 3'd2, 8'hFF);
    ena = 1'b1; din = 8'h0F;
    step(); step();
    check_vec("inv_valid", 32'(dout_valid), 32'h1);
    check_vec("inv_dout",  32'(dout), 32'hF0);
    check_vec("inv_oe",    32'(oe), 32'hFF);
    ena = 1'b0;

    // EDGE d=2
    configure(2'd2, 3'd2, 8'hFF);
    ena = 1'b1; din = 8'h00;
    step(); step();
    check_vec("edge_quiet", 32'(dout), 32'h00);
    din = 8'hFF; step();
    check_vec("edge_rise", 32'(dout), 32'hFF);
    step();
    check_vec("edge_settle", 32'(dout), 32'h00);
    ena = 1'b0;

    // cfg_delay 0 clamps to 1
    configure(2'd0, 3'd0, 8'hAA);
    ena = 1'b1; din = 8'h5A; step();
    check_vec("clamp0_valid", 32'(dout_valid), 32'h1);
    check_vec("clamp0_dout",  32'(dout), 32'h5A);
    ena = 1'b0;

    // cfg_delay 7 clamps to DEPTH = 4
    configure(2'd0, 3'd7, 8'h3C);
    ena = 1'b1;
    din = 8'h11; step();
    din = 8'h22; step();
    din = 8'h33; step();
    check_vec("clamp7_valid3", 32'(dout_valid), 32'h0);
    din = 8'h44; step();
    check_vec("clamp7_valid4", 32'(dout_valid), 32'h1);
    check_vec("clamp7_dout",   32'(dout), 32'h11);
    ena = 1'b0;

    // OFF
    configure(2'd3, 3'd1, 8'hFF);
    check_vec("off_oe", 32'(oe), 32'h0);
    ena = 1'b1; din = 8'h99;
    step(); step();
    check_vec("off_dout",  32'(dout), 32'h0);
    check_vec("off_valid", 32'(dout_valid), 32'h0);
    ena = 1'b0;

    // ena low mid-fill holds line and counter
    configure(2'd0, 3'd3, 8'hFF);
    ena = 1'b1;
    din = 8'hA1; step();
    din = 8'hB2; step();
    ena = 1'b0; din = 8'hC3;
    for (int i = 0; i < 5; i++) step();
    check_vec("hold_valid", 32'(dout_valid), 32'h0);
    check_vec("hold_s0",    32'(dut.stages[0]), 32'hB2);
    ena = 1'b1; din = 8'hD4; step();
    check_vec("hold_resume_valid", 32'(dout_valid), 32'h1);
    check_vec("hold_resume_dout",  32'(dout), 32'hA1);

    // accept in the same cycle as ena: line shifts, fill restarts
    cfg_mode = 2'd0; cfg_delay = 3'd2; cfg_oe = 8'h0F; cfg_valid = 1'b1;
    din = 8'hE5; step();
    cfg_valid = 1'b0;
    check_vec("sim_s0",    32'(dut.stages[0]), 32'hE5);
    check_vec("sim_s1",    32'(dut.stages[1]), 32'hD4);
    check_vec("sim_valid", 32'(dout_valid), 32'h0);
    check_vec("sim_ready", 32'(cfg_ready), 32'h0);
    din = 8'hF6; step();
    check_vec("sim_fc1_valid", 32'(dout_valid), 32'h0);
    din = 8'h07; step();
    check_vec("sim_fc2_valid", 32'(dout_valid), 32'h1);
    check_vec("sim_dout",      32'(dout), 32'hF6);
    ena = 1'b0;

    // reset during an accept cycle
    configure(2'd1, 3'd2, 8'hFF);
    ena = 1'b1; din = 8'h0F;
    step(); step();
    check_vec("pre_rst_dout", 32'(dout), 32'hF0);
    cfg_mode = 2'd2; cfg_delay = 3'd3; cfg_oe = 8'h0F; cfg_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_vec("arst_dout",  32'(dout), 32'h0);
    check_vec("arst_valid", 32'(dout_valid), 32'h0);
    check_vec("arst_oe",    32'(oe), 32'h0);
    check_vec("arst_mode",  32'(mode), 32'h0);
    check_vec("arst_ready", 32'(cfg_ready), 32'h1);
    check_vec("arst_s0",    32'(dut.stages[0]), 32'h0);
    step();
    rst = 1'b0; cfg_valid = 1'b0; ena = 1'b0;
    check_vec("post_rst_mode", 32'(mode), 32'h0);
    check_vec("post_rst_oe",   32'(oe), 32'h0);
    ena = 1'b1; din = 8'h77; step();
    check_vec("post_rst_valid", 32'(dout_valid), 32'h1);
    check_vec("post_rst_dout",  32'(dout), 32'h77);
    check_vec("post_rst_ready", 32'(cfg_ready), 32'h1);
    ena = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
